ps2_scancode_filter: RTL and testbench

PS2_SCANCODE_FILTER -- requirements
Module: ps2_scancode_filter

---
 rtl/ps2_scancode_filter.sv | 149 ++++++++++++++
 tb/tb_ps2_scancode_filter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_filter.sv
// PS/2 scancode decoder: folds E0/F0 prefixes into {ext, brk, code} events and queues them in a show-ahead FIFO.
// Optional macro TYPEMATIC_FILTER_EN suppresses auto-repeat presses of the currently held key.
module ps2_scancode_filter #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       flag,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [4:0] count,
  output logic       overflow,
  output logic       proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t state, state_next;
  logic   emit, err;
  event_t ev;
  logic   push;

  // Prefix decoder: advances only on flag cycles, emits at most one event per byte
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    err        = 1'b0;
    ev         = '{ext: 1'b0, brk: 1'b0, code: scancode};
    if (flag) begin
      case (state)
        IDLE: begin
          if (scancode == 8'hE0)      state_next = GOT_E0;
          else if (scancode == 8'hF0) state_next = GOT_F0;
          else if (!(scancode inside {8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF})) emit = 1'b1;
        end
        GOT_E0: begin
          if (scancode == 8'hF0) state_next = GOT_E0F0;
          else if (scancode != 8'hE0) begin
            emit       = 1'b1;
            ev.ext     = 1'b1;
            state_next = IDLE;
          end
        end
        GOT_F0: begin
          state_next = IDLE;
          if (scancode == 8'hE0 || scancode == 8'hF0) err = 1'b1;
          else begin
            emit   = 1'b1;
            ev.brk = 1'b1;
          end
        end
        GOT_E0F0: begin
          state_next = IDLE;
          if (scancode == 8'hE0 || scancode == 8'hF0) err = 1'b1;
          else begin
            emit   = 1'b1;
            ev.ext = 1'b1;
            ev.brk = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       held_valid;
  logic       held_ext;
  logic [7:0] held_code;
  logic       same_key;

  assign same_key = held_valid && (held_ext == ev.ext) && (held_code == ev.code);
  assign push     = emit && (ev.brk || !same_key);

  // Held key tracks the last press even if its event was dropped on overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
    end else if (emit) begin
      if (!ev.brk) begin
        held_valid <= 1'b1;
        held_ext   <= ev.ext;
        held_code  <= ev.code;
      end else if (same_key) begin
        held_valid <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  event_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic            full, pop, push_acc;
  logic [4:0]      count_next;
  event_t          head_next;

  assign full       = (count == 5'(DEPTH));
  assign pop        = key_valid && key_ready;
  assign push_acc   = push && (!full || pop);
  assign rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_next = count + 5'(push_acc) - 5'(pop);
  // A push landing in the slot that becomes head bypasses the memory
  assign head_next  = (push_acc && (wr_ptr == rd_next)) ? ev : mem[rd_next];

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 5'd0;
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      rd_ptr    <= rd_next;
      count     <= count_next;
      key_valid <= (count_next != 5'd0);
      overflow  <= push && full && !pop;
      proto_err <= err;
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (count_next != 5'd0) {key_ext, key_break, key_code} <= head_next;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_filter.sv
// Scoreboard bench for ps2_scancode_filter: a prefix/queue reference model predicts events, a negedge monitor checks them.
module tb_ps2_scancode_filter;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scancode;
  logic       flag;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_ready;
  logic [4:0] count;
  logic       overflow;
  logic       proto_err;

  ps2_scancode_filter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_valid(key_valid), .key_ready(key_ready), .count(count),
    .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  int   occ = 0;
  bit   exp_ovf = 0, exp_err = 0;
  bit   pend_e0 = 0, pend_f0 = 0;
  bit   have;
  ev_t  e;
  ev_t  last_head = '0;
`ifdef TYPEMATIC_FILTER_EN
  bit        held_v = 0;
  logic [8:0] held = '0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events from prefix rules, FIFO as an occupancy count plus queue
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      exp_q.delete();
      occ = 0; exp_ovf = 0; exp_err = 0; pend_e0 = 0; pend_f0 = 0;
`ifdef TYPEMATIC_FILTER_EN
      held_v = 0;
`endif
    end else begin
      have = 0; exp_ovf = 0; exp_err = 0;
      if (occ > 0 && key_ready) occ--;
      if (flag) begin
        if (scancode == 8'hE0 || scancode == 8'hF0) begin
          if (pend_f0) begin
            exp_err = 1; pend_e0 = 0; pend_f0 = 0;
          end else if (scancode == 8'hE0) pend_e0 = 1;
          else pend_f0 = 1;
        end else if (!pend_e0 && !pend_f0 &&
                     (scancode inside {8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF})) begin
          have = 0;
        end else begin
          have = 1;
          e = '{ext: pend_e0, brk: pend_f0, code: scancode};
          pend_e0 = 0; pend_f0 = 0;
        end
      end
`ifdef TYPEMATIC_FILTER_EN
      if (have) begin
        if (!e.brk) begin
          if (held_v && held == {e.ext, e.code}) have = 0;
          else begin held_v = 1; held = {e.ext, e.code}; end
        end else if (held_v && held == {e.ext, e.code}) held_v = 0;
      end
`endif
      if (have) begin
        if (occ < DEPTH) begin
          occ++;
          exp_q.push_back(e);
        end else exp_ovf = 1;
      end
    end
  end

  // Monitor: checks status every cycle and pops the scoreboard on each handshake
  initial forever begin
    @(negedge clk);
    if (reset) last_head = '0;
    else begin
      chk("count", int'(count), occ);
      chk("key_valid", int'(key_valid), (occ > 0) ? 1 : 0);
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("proto_err", int'(proto_err), int'(exp_err));
      if (key_valid) begin
        if (exp_q.size() == 0) chk("unexpected_event", int'(key_code), -1);
        else begin
          chk("key_code", int'(key_code), int'(exp_q[0].code));
          chk("key_ext", int'(key_ext), int'(exp_q[0].ext));
          chk("key_break", int'(key_break), int'(exp_q[0].brk));
          if (key_ready) last_head = exp_q.pop_front();
        end
      end else begin
        chk("hold_code", int'(key_code), int'(last_head.code));
        chk("hold_flags", int'({key_ext, key_break}), int'({last_head.ext, last_head.brk}));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    scancode = b;
    flag = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [7:0] tbl [10];
  logic [7:0] b;

  initial begin
    tbl = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'h5A};
    reset = 1'b1; flag = 1'b0; scancode = 8'h00; key_ready = 1'b1;
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_head", int'({key_ext, key_break, key_code}), 0);
    chk("rst_pulses", int'({overflow, proto_err}), 0);
    @(posedge clk); #1 reset = 1'b0;

    send(8'h1C); idle(2); send(8'hF0); send(8'h1C); idle(3);
    send(8'hE0); send(8'h75); send(8'hAA); send(8'hFA);
    send(8'hE0); send(8'hF0); send(8'h75); idle(3);

    key_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    idle(2);
    key_ready = 1'b1; send(8'h30); key_ready = 1'b0;
    idle(2);
    key_ready = 1'b1; idle(12);

    send(8'hF0); send(8'hE0); send(8'h1C); idle(2);
    send(8'hE0); do_reset(); send(8'h1C); idle(3);

    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); idle(3);

    for (int i = 0; i < 600; i++) begin
      key_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 150) == 0) do_reset();
      else if ($urandom_range(0, 2) != 0) begin
        b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 9)];
        send(b);
      end else idle(1);
    end

    key_ready = 1'b1;
    idle(2 * DEPTH + 4);
    chk("drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
